// File: rtl/rv32i_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/memory-size codes and the
// control bundle passed from decode to execute.
package rv32i_decode_pkg;

  localparam int CtrlAluW = 5;

  localparam logic [6:0] OPPI   = 7'b0010011;
  localparam logic [6:0] OPPR   = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  // CPY sits in the 11xxx range, which no {funct7==1, ins[30], funct3} code can reach
  localparam logic [CtrlAluW-1:0] ADD = 5'b00000;
  localparam logic [CtrlAluW-1:0] CPY = 5'b11111;

  localparam logic [2:0] MS_B  = 3'd0;
  localparam logic [2:0] MS_H  = 3'd1;
  localparam logic [2:0] MS_W  = 3'd2;
  localparam logic [2:0] MS_BU = 3'd4;
  localparam logic [2:0] MS_HU = 3'd5;

  typedef struct packed {
    logic                RegWriteControl;
    logic                LinkAddrWrite;
    logic [2:0]          BranchType;
    logic                TestBranch;
    logic                AlwaysBranch;
    logic                AbsoluteBranch;
    logic                UseImm;
    logic                UsePC;
    logic [CtrlAluW-1:0] ALUCode;
    logic                RAMWrite;
    logic                RAMRead;
    logic [2:0]          MemSize;
  } decode_ctrl_t;

endpackage

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I(+M) instruction decoder: control bundle, immediate,
// illegal flag and register-port usage for hazard detection.
module rv32i_decode_comb
  import rv32i_decode_pkg::*;
#(
  parameter int EN_MEXT = 0
) (
  input  logic [31:0]  instr,
  output decode_ctrl_t ctrl,
  output logic [31:0]  imm,
  output logic         illegal,
  output logic         usesRs1,
  output logic         usesRs2
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] iImm, sImm, bImm, uImm, jImm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign iImm = {{20{instr[31]}}, instr[31:20]};
  assign sImm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign bImm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign uImm = {instr[31:12], 12'b0};
  assign jImm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    ctrl    = '0;
    imm     = '0;
    illegal = 1'b0;
    usesRs1 = 1'b0;
    usesRs2 = 1'b0;
    case (opcode)
      OPPI: begin
        imm                  = iImm;
        usesRs1              = 1'b1;
        ctrl.UseImm          = 1'b1;
        ctrl.RegWriteControl = 1'b1;
        ctrl.ALUCode         = {1'b0, (funct3 == 3'd5) & instr[30], funct3};
        if (funct3 == 3'd1)
          illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'd5)
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPPR: begin
        usesRs1              = 1'b1;
        usesRs2              = 1'b1;
        ctrl.RegWriteControl = 1'b1;
        ctrl.ALUCode         = {funct7 == 7'b0000001, instr[30], funct3};
        case (funct7)
          7'b0000000: illegal = 1'b0;
          7'b0100000: illegal = !((funct3 == 3'd0) || (funct3 == 3'd5));
          7'b0000001: illegal = (EN_MEXT == 0);
          default:    illegal = 1'b1;
        endcase
      end
      LUI: begin
        imm                  = uImm;
        ctrl.ALUCode         = CPY;
        ctrl.RegWriteControl = 1'b1;
      end
      AUIPC: begin
        imm                  = uImm;
        ctrl.UsePC           = 1'b1;
        ctrl.ALUCode         = ADD;
        ctrl.RegWriteControl = 1'b1;
      end
      JAL: begin
        imm                = jImm;
        ctrl.AlwaysBranch  = 1'b1;
        ctrl.LinkAddrWrite = 1'b1;
      end
      JALR: begin
        imm                 = iImm;
        usesRs1             = 1'b1;
        ctrl.AlwaysBranch   = 1'b1;
        ctrl.AbsoluteBranch = 1'b1;
        ctrl.ALUCode        = ADD;
        ctrl.LinkAddrWrite  = 1'b1;
        illegal             = (funct3 != 3'd0);
      end
      BRANCH: begin
        imm             = bImm;
        usesRs1         = 1'b1;
        usesRs2         = 1'b1;
        ctrl.TestBranch = 1'b1;
        ctrl.UsePC      = 1'b1;
        ctrl.UseImm     = 1'b1;
        ctrl.ALUCode    = ADD;
        ctrl.BranchType = funct3;
        illegal         = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      LOAD: begin
        imm                  = iImm;
        usesRs1              = 1'b1;
        ctrl.UseImm          = 1'b1;
        ctrl.ALUCode         = ADD;
        ctrl.RAMRead         = 1'b1;
        ctrl.MemSize         = funct3;
        ctrl.RegWriteControl = 1'b1;
        illegal              = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      STORE: begin
        imm           = sImm;
        usesRs1       = 1'b1;
        usesRs2       = 1'b1;
        ctrl.UseImm   = 1'b1;
        ctrl.ALUCode  = ADD;
        ctrl.RAMWrite = 1'b1;
        ctrl.MemSize  = funct3;
        illegal       = (funct3 > 3'd2);
      end
      default: illegal = 1'b1;
    endcase
    // x0 is hard-wired zero, so a write to it is pointless
    if (instr[11:7] == 5'd0) ctrl.RegWriteControl = 1'b0;
    // illegal instructions still flow, but must not write, branch or touch memory
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/decode_stage_rv32i.sv
// Registered RV32I decode stage: one-entry valid/ready output register with
// flush and load-use bubble insertion between fetch and execute.
module decode_stage_rv32i
  import rv32i_decode_pkg::*;
#(
  parameter int dataW    = 32,
  parameter int RegAddrW = 5,
  parameter int ALUCodeW = 5,
  parameter int EN_MEXT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Flush,
  input  logic                InValid,
  output logic                InReady,
  input  logic [dataW-1:0]    InInstr,
  input  logic [dataW-1:0]    InPC,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [dataW-1:0]    OutPC,
  output logic [RegAddrW-1:0] RegData1,
  output logic [RegAddrW-1:0] RegData2,
  output logic [RegAddrW-1:0] RegWriteAddr,
  output logic [dataW-1:0]    ImmOut,
  output decode_ctrl_t        Ctrl,
  output logic                Illegal
);

  if (dataW != 32 || ALUCodeW != CtrlAluW || RegAddrW != 5) begin : gBadParams
    $error("decode_stage_rv32i: unsupported parameter set");
  end

  decode_ctrl_t decCtrl;
  logic [31:0]  decImm;
  logic         decIllegal;
  logic         decUsesRs1;
  logic         decUsesRs2;
  logic         hazard;
  logic         accept;

  rv32i_decode_comb #(.EN_MEXT(EN_MEXT)) uDecode (
    .instr   (InInstr),
    .ctrl    (decCtrl),
    .imm     (decImm),
    .illegal (decIllegal),
    .usesRs1 (decUsesRs1),
    .usesRs2 (decUsesRs2)
  );

  // A registered load whose rd feeds the incoming instruction forces one bubble
  assign hazard = OutValid & Ctrl.RAMRead & (RegWriteAddr != '0) & InValid &
                  ((decUsesRs1 & (InInstr[19:15] == RegWriteAddr)) |
                   (decUsesRs2 & (InInstr[24:20] == RegWriteAddr)));

  assign InReady = ~rst & ~Flush & ~hazard & (~OutValid | OutReady);
  assign accept  = InValid & InReady;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      OutValid     <= 1'b0;
      OutPC        <= '0;
      RegData1     <= '0;
      RegData2     <= '0;
      RegWriteAddr <= '0;
      ImmOut       <= '0;
      Ctrl         <= '0;
      Illegal      <= 1'b0;
    end else if (Flush) begin
      OutValid <= 1'b0;
    end else if (accept) begin
      OutValid     <= 1'b1;
      OutPC        <= InPC;
      RegData1     <= InInstr[19:15];
      RegData2     <= InInstr[24:20];
      RegWriteAddr <= InInstr[11:7];
      ImmOut       <= decImm;
      Ctrl         <= decCtrl;
      Illegal      <= decIllegal;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_rv32i.sv
// Self-checking bench for decode_stage_rv32i: directed plan steps, then random
// traffic compared against a transaction-level reference model.
module tb_decode_stage_rv32i;
  import rv32i_decode_pkg::*;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  imm;
    decode_ctrl_t ctrl;
    logic         ill;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Flush = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic [31:0] InInstr = '0, InPC = '0;

  logic InReady, OutValid, Illegal;
  logic [31:0] OutPC, ImmOut;
  logic [4:0] RegData1, RegData2, RegWriteAddr;
  decode_ctrl_t Ctrl;

  logic InReadyM, OutValidM, IllegalM;
  logic [31:0] OutPCM, ImmOutM;
  logic [4:0] RegData1M, RegData2M, RegWriteAddrM;
  decode_ctrl_t CtrlM;

  int nChecks = 0;
  int nPass   = 0;

  bit     mValid = 1'b0;
  entry_t mEnt   = '0;

  always #5 clk = ~clk;

  decode_stage_rv32i #(.EN_MEXT(0)) dut (
    .clk(clk), .rst(rst), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .InInstr(InInstr), .InPC(InPC), .OutValid(OutValid), .OutReady(OutReady),
    .OutPC(OutPC), .RegData1(RegData1), .RegData2(RegData2),
    .RegWriteAddr(RegWriteAddr), .ImmOut(ImmOut), .Ctrl(Ctrl), .Illegal(Illegal)
  );

  decode_stage_rv32i #(.EN_MEXT(1)) dutM (
    .clk(clk), .rst(rst), .Flush(Flush), .InValid(InValid), .InReady(InReadyM),
    .InInstr(InInstr), .InPC(InPC), .OutValid(OutValidM), .OutReady(OutReady),
    .OutPC(OutPCM), .RegData1(RegData1M), .RegData2(RegData2M),
    .RegWriteAddr(RegWriteAddrM), .ImmOut(ImmOutM), .Ctrl(CtrlM), .Illegal(IllegalM)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit usesRs1(input logic [31:0] ins);
    return ins[6:0] inside {OPPI, OPPR, JALR, BRANCH, LOAD, STORE};
  endfunction

  function automatic bit usesRs2(input logic [31:0] ins);
    return ins[6:0] inside {OPPR, BRANCH, STORE};
  endfunction

  // Reference decode written from the instruction-set rules with plain arithmetic
  function automatic entry_t refDecode(input logic [31:0] ins, input logic [31:0] pc, input bit mext);
    entry_t e = '0;
    logic signed [31:0] s = ins;
    logic [31:0] iv = 32'(s >>> 20);
    logic [31:0] sgn12 = ins[31] ? 32'hFFFFF000 : 32'h0;
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    e.pc  = pc;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    case (ins[6:0])
      OPPI: begin
        e.imm = iv;
        e.ctrl.UseImm = 1'b1;
        e.ctrl.RegWriteControl = 1'b1;
        e.ctrl.ALUCode = 5'(f3) + ((f3 == 3'd5 && ins[30]) ? 5'd8 : 5'd0);
        e.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPPR: begin
        e.ctrl.RegWriteControl = 1'b1;
        e.ctrl.ALUCode = 5'(f3) + (ins[30] ? 5'd8 : 5'd0) + ((f7 == 7'h01) ? 5'd16 : 5'd0);
        e.ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && mext));
      end
      LUI: begin
        e.imm = ins & 32'hFFFFF000;
        e.ctrl.ALUCode = CPY;
        e.ctrl.RegWriteControl = 1'b1;
      end
      AUIPC: begin
        e.imm = ins & 32'hFFFFF000;
        e.ctrl.UsePC = 1'b1;
        e.ctrl.ALUCode = ADD;
        e.ctrl.RegWriteControl = 1'b1;
      end
      JAL: begin
        e.imm = (32'(ins[30:21]) << 1) | (32'(ins[20]) << 11) | (32'(ins[19:12]) << 12) |
                (ins[31] ? 32'hFFF00000 : 32'h0);
        e.ctrl.AlwaysBranch = 1'b1;
        e.ctrl.LinkAddrWrite = 1'b1;
      end
      JALR: begin
        e.imm = iv;
        e.ctrl.AlwaysBranch = 1'b1;
        e.ctrl.AbsoluteBranch = 1'b1;
        e.ctrl.ALUCode = ADD;
        e.ctrl.LinkAddrWrite = 1'b1;
        e.ill = (f3 != 3'd0);
      end
      BRANCH: begin
        e.imm = (32'(ins[11:8]) << 1) | (32'(ins[30:25]) << 5) | (32'(ins[7]) << 11) | sgn12;
        e.ctrl.TestBranch = 1'b1;
        e.ctrl.UsePC = 1'b1;
        e.ctrl.UseImm = 1'b1;
        e.ctrl.ALUCode = ADD;
        e.ctrl.BranchType = f3;
        e.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      LOAD: begin
        e.imm = iv;
        e.ctrl.UseImm = 1'b1;
        e.ctrl.ALUCode = ADD;
        e.ctrl.RAMRead = 1'b1;
        e.ctrl.MemSize = f3;
        e.ctrl.RegWriteControl = 1'b1;
        e.ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      STORE: begin
        e.imm = (32'(s >>> 25) << 5) | 32'(ins[11:7]);
        e.ctrl.UseImm = 1'b1;
        e.ctrl.ALUCode = ADD;
        e.ctrl.RAMWrite = 1'b1;
        e.ctrl.MemSize = f3;
        e.ill = (f3 > 3'd2);
      end
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.ctrl.RegWriteControl = 1'b0;
    if (e.ill) e.ctrl = '0;
    return e;
  endfunction

  // One clock of stimulus: drive after the edge, check at the falling edge, advance the model
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic r);
    bit haz, expRdy;
    @(posedge clk);
    #1;
    rst = r; InValid = v; InInstr = ins; InPC = pc; OutReady = ordy; Flush = fl;
    @(negedge clk);
    haz = mValid && mEnt.ctrl.RAMRead && (mEnt.rd != 5'd0) && v &&
          ((usesRs1(ins) && ins[19:15] == mEnt.rd) || (usesRs2(ins) && ins[24:20] == mEnt.rd));
    expRdy = !r && !fl && !haz && (!mValid || ordy);
    check("InReady", 64'(InReady), 64'(expRdy));
    check("OutValid", 64'(OutValid), 64'(mValid));
    if (mValid) begin
      check("OutPC", 64'(OutPC), 64'(mEnt.pc));
      check("ImmOut", 64'(ImmOut), 64'(mEnt.imm));
      check("Ctrl", 64'(Ctrl), 64'(mEnt.ctrl));
      check("Illegal", 64'(Illegal), 64'(mEnt.ill));
      check("RegWriteAddr", 64'(RegWriteAddr), 64'(mEnt.rd));
      check("RegData1", 64'(RegData1), 64'(mEnt.rs1));
      check("RegData2", 64'(RegData2), 64'(mEnt.rs2));
    end
    if (r) begin
      mValid = 1'b0;
      mEnt = '0;
    end else if (fl) begin
      mValid = 1'b0;
    end else if (v && expRdy) begin
      mValid = 1'b1;
      mEnt = refDecode(ins, pc, 1'b0);
    end else if (ordy) begin
      mValid = 1'b0;
    end
  endtask

  function automatic logic [31:0] genInstr();
    logic [6:0] op;
    logic [6:0] f7;
    case ($urandom_range(0, 11))
      0:       op = OPPI;
      1:       op = OPPR;
      2:       op = LUI;
      3:       op = AUIPC;
      4:       op = JAL;
      5:       op = JALR;
      6:       op = BRANCH;
      7, 8:    op = LOAD;
      9:       op = STORE;
      10:      op = OPPR;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), op};
  endfunction

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADD   = 32'h00528333;
  localparam logic [31:0] I_SW    = 32'h0050A423;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_NOP   = 32'h00000013;

  initial begin
    entry_t mulRef;

    // Reset state; InReady must stay low while rst is high
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, I_ADDI, 32'h100, 1, 0, 1);
    check("rst_InReady", 64'(InReady), 64'd0);
    check("rst_OutValid", 64'(OutValid), 64'd0);
    check("rst_Illegal", 64'(Illegal), 64'd0);
    check("rst_Ctrl", 64'(Ctrl), 64'd0);
    check("rst_ImmOut", 64'(ImmOut), 64'd0);
    check("rst_OutPC", 64'(OutPC), 64'd0);
    check("rst_regs", 64'({RegData1, RegData2, RegWriteAddr}), 64'd0);

    // ADDI x1,x0,5 appears one cycle after acceptance
    cycle(1, I_ADDI, 32'h100, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("addi_valid", 64'(OutValid), 64'd1);
    check("addi_imm", 64'(ImmOut), 64'd5);
    check("addi_rd", 64'(RegWriteAddr), 64'd1);
    check("addi_useimm", 64'(Ctrl.UseImm), 64'd1);
    check("addi_alu", 64'(Ctrl.ALUCode), 64'(ADD));
    check("addi_illegal", 64'(Illegal), 64'd0);

    // LW then dependent ADD: exactly one bubble
    cycle(1, I_LW, 32'h104, 1, 0, 0);
    cycle(1, I_ADD, 32'h108, 1, 0, 0);
    check("lw_ramread", 64'(Ctrl.RAMRead), 64'd1);
    check("hazard_inready", 64'(InReady), 64'd0);
    cycle(1, I_ADD, 32'h108, 1, 0, 0);
    check("bubble_valid", 64'(OutValid), 64'd0);
    check("bubble_inready", 64'(InReady), 64'd1);
    cycle(1, I_SW, 32'h10C, 1, 0, 0);
    check("add_rd", 64'(RegWriteAddr), 64'd6);
    check("add_pc", 64'(OutPC), 64'h108);

    // SW held for three cycles with execute stalled
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h00100113, 32'h110, 0, 0, 0);
      check("sw_valid", 64'(OutValid), 64'd1);
      check("sw_imm", 64'(ImmOut), 64'd8);
      check("sw_ramwrite", 64'(Ctrl.RAMWrite), 64'd1);
      check("sw_memsize", 64'(Ctrl.MemSize), 64'(MS_W));
      check("sw_regwrite", 64'(Ctrl.RegWriteControl), 64'd0);
      check("sw_inready", 64'(InReady), 64'd0);
      check("sw_pc", 64'(OutPC), 64'h10C);
    end
    cycle(1, 32'h00100113, 32'h110, 1, 0, 0);
    check("sw_release", 64'(InReady), 64'd1);

    // Flush while valid and offered: the offered ADDI x4 must never appear
    cycle(1, 32'h00300193, 32'h114, 1, 0, 0);
    cycle(1, 32'h00700213, 32'h118, 0, 1, 0);
    check("flush_held_valid", 64'(OutValid), 64'd1);
    cycle(0, 0, 0, 1, 0, 0);
    check("flush_valid", 64'(OutValid), 64'd0);
    cycle(0, 0, 0, 1, 0, 0);
    check("flush_dropped", 64'(OutValid), 64'd0);

    // Illegal encodings and the M extension
    cycle(1, 32'hFFFFFFFF, 32'h200, 1, 0, 0);
    cycle(1, I_MUL, 32'h204, 1, 0, 0);
    check("ffff_illegal", 64'(Illegal), 64'd1);
    check("ffff_ctrl", 64'(Ctrl), 64'd0);
    cycle(1, I_NOP, 32'h208, 1, 0, 0);
    check("mul_illegal", 64'(Illegal), 64'd1);
    check("mul_ctrl", 64'(Ctrl), 64'd0);
    mulRef = refDecode(I_MUL, 32'h204, 1'b1);
    check("mulM_valid", 64'(OutValidM), 64'd1);
    check("mulM_illegal", 64'(IllegalM), 64'd0);
    check("mulM_alu", 64'(CtrlM.ALUCode), 64'h10);
    check("mulM_ctrl", 64'(CtrlM), 64'(mulRef.ctrl));
    check("mulM_imm", 64'(ImmOutM), 64'(mulRef.imm));
    check("mulM_pc", 64'(OutPCM), 64'h204);
    check("mulM_regs", 64'({RegData1M, RegData2M, RegWriteAddrM}), 64'({5'd1, 5'd2, 5'd3}));
    check("mulM_inready", 64'(InReadyM), 64'd1);

    // ADDI x0 never writes; then reset in the middle of a stall
    cycle(1, I_LW, 32'h20C, 1, 0, 0);
    check("nop_regwrite", 64'(Ctrl.RegWriteControl), 64'd0);
    check("nop_illegal", 64'(Illegal), 64'd0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("stall_valid", 64'(OutValid), 64'd1);
    cycle(0, 0, 0, 0, 0, 0);
    check("midrst_valid", 64'(OutValid), 64'd0);
    check("midrst_pc", 64'(OutPC), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), genInstr(), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
